// File: rtl/mvu_csr_apb_if.sv
// APB3/4 completer-side signal bundle for the MVU CSR block.
interface mvu_csr_apb_if #(
    parameter int APB_ADDR_WIDTH = 15,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_STRB_WIDTH = APB_DATA_WIDTH / 8
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_STRB_WIDTH-1:0] pstrb;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/mvu_csr_apb.sv
// APB CSR file for NMVU matrix-vector units: strobed writes, registered reads,
// command/busy/done tracking and per-MVU level interrupts, all exposed on cfg_o.
module mvu_csr_apb #(
    parameter int          NMVU           = 8,
    parameter int          NJUMPS         = 5,
    parameter logic [11:0] CSRBASE        = 12'hf20,
    parameter int          NREG           = 74,
    parameter int          APB_ADDR_WIDTH = 15,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          APB_STRB_WIDTH = APB_DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mvu_csr_apb_if.slave           apb,
    output logic [NMVU*NREG*32-1:0] cfg_o,
    output logic [NMVU-1:0]        start_o,
    input  logic [NMVU-1:0]        done_i,
    output logic [NMVU-1:0]        busy_o,
    output logic [NMVU-1:0]        irq_o
);
    localparam int BMVUA      = (NMVU > 1) ? $clog2(NMVU) : 1;
    localparam int BREG       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int STATUS_OFS = 'hf54 - int'(CSRBASE);
    localparam logic [BREG-1:0] STATUS_IDX  = BREG'(STATUS_OFS);
    localparam logic [BREG-1:0] COMMAND_IDX = BREG'(STATUS_OFS + 1);

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_CAP, RD_RESP} state_t;

    state_t state_q, state_d;

    logic [31:0] regs [NMVU][NREG];

    logic [NMVU-1:0] busy_q, done_q, start_q;
    logic [NMVU-1:0] kick, clr;

    // Access decode captured when the FSM leaves IDLE
    logic                      valid_q;
    logic [BMVUA-1:0]          m_q;
    logic [BREG-1:0]           r_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [APB_STRB_WIDTH-1:0] strb_q;
    logic [31:0]               rdata_q;

    logic        latch, capture, commit, cmd_busy, addr_ok;
    logic [2:0]  sel_mvu;
    logic [11:0] csr_num, r_full;
    logic [31:0] rd_mux;

    assign sel_mvu = apb.paddr[14:12];
    assign csr_num = apb.paddr[11:0];
    assign r_full  = csr_num - CSRBASE;
    assign addr_ok = (NJUMPS > 0) && (32'(sel_mvu) < NMVU)
                  && (csr_num >= CSRBASE) && (32'(r_full) < NREG);

    // Busy is judged from registered state; a done pulse in the accept cycle has already landed
    assign cmd_busy = valid_q && (r_q == COMMAND_IDX) && busy_q[m_q];

    always_comb begin
        rd_mux = '0;
        if (valid_q) begin
            rd_mux = (r_q == STATUS_IDX) ? {30'b0, done_q[m_q], busy_q[m_q]}
                                         : regs[m_q][r_q];
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        capture     = 1'b0;
        commit      = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (apb.psel && apb.penable) begin
                    latch   = 1'b1;
                    state_d = apb.pwrite ? WR_RESP : RD_CAP;
                end
            end
            WR_RESP: begin
                apb.pready  = 1'b1;
                apb.pslverr = !valid_q || cmd_busy;
                commit      = valid_q && !cmd_busy;
                state_d     = IDLE;
            end
            RD_CAP: begin
                capture = 1'b1;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                apb.pready  = 1'b1;
                apb.pslverr = !valid_q;
                apb.prdata  = APB_DATA_WIDTH'(rdata_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        kick = '0;
        clr  = '0;
        for (int m = 0; m < NMVU; m++) begin
            if (commit && (m_q == BMVUA'(m))) begin
                kick[m] = (r_q == COMMAND_IDX);
                clr[m]  = (r_q == STATUS_IDX) && strb_q[0] && wdata_q[1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            m_q     <= '0;
            r_q     <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                valid_q <= addr_ok;
                m_q     <= sel_mvu[BMVUA-1:0];
                r_q     <= r_full[BREG-1:0];
                wdata_q <= apb.pwdata;
                strb_q  <= apb.pstrb;
            end
            if (capture) begin
                rdata_q <= rd_mux;
            end
            // A completion that coincides with a W1C clear keeps done set
            busy_q  <= (busy_q & ~done_i) | kick;
            done_q  <= (done_q & ~clr) | (done_i & busy_q);
            start_q <= kick;
        end
    end

    // NOTE: the register array is reset because cfg_o drives it straight into the MVUs,
    // which must never see undefined configuration after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < NMVU; m++) begin
                for (int r = 0; r < NREG; r++) begin
                    regs[m][r] <= '0;
                end
            end
        end else if (commit && (r_q != STATUS_IDX)) begin
            for (int b = 0; b < APB_STRB_WIDTH; b++) begin
                if (strb_q[b]) begin
                    regs[m_q][r_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // STATUS has no storage; its slot mirrors live busy/done
    always_comb begin
        cfg_o = '0;
        for (int m = 0; m < NMVU; m++) begin
            for (int r = 0; r < NREG; r++) begin
                if (r == STATUS_OFS) begin
                    cfg_o[(m*NREG + r)*32 +: 32] = {30'b0, done_q[m], busy_q[m]};
                end else begin
                    cfg_o[(m*NREG + r)*32 +: 32] = regs[m][r];
                end
            end
        end
    end

    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign irq_o   = done_q;

endmodule
